// File: rtl/ballot_entry_unit.sv
// Voter-side front end: debounces candidate buttons into one 4-bit code offered on a valid/ack handshake.
// Optional auto-cancel of an idle authorization is built when BALLOT_TIMEOUT_EN is defined.
module ballot_entry_unit #(
  parameter int unsigned NUM_CAND       = 15,
  parameter int unsigned DEB_CYCLES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ballot_en,
  input  logic [NUM_CAND-1:0] btn,
  output logic [3:0]          vote_code,
  output logic                vote_valid,
  input  logic                vote_ack,
  output logic                ready_led,
  output logic                busy_led,
  output logic                invalid_press,
  output logic                timeout
);

  localparam int unsigned CW = $clog2(DEB_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = (DEB_CYCLES >= 2) ? CW'(DEB_CYCLES - 2) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DEBOUNCE,
    S_PRESENT,
    S_RELEASE
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_CAND-1:0] btn_q;
  logic                en_q, en_prev_q;
  logic [NUM_CAND-1:0] cap_q, cap_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [3:0]          code_q, code_d;
  logic                multi_q, multi_d;
  logic                inv_q, inv_d;
  logic                tmo_hit;

  function automatic logic [3:0] code_of(input logic [NUM_CAND-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int unsigned k = 0; k < NUM_CAND; k++) begin
      if (v[k]) c = 4'(k + 1);
    end
    return c;
  endfunction

  // en_prev_q is forced high in reset so a level already high at reset release is not an edge.
  always_ff @(posedge clk) begin
    en_q <= ballot_en;
    if (rst) begin
      state_q   <= S_IDLE;
      btn_q     <= '0;
      en_prev_q <= 1'b1;
      cap_q     <= '0;
      cnt_q     <= '0;
      code_q    <= '0;
      multi_q   <= 1'b0;
      inv_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      btn_q     <= btn;
      en_prev_q <= en_q;
      cap_q     <= cap_d;
      cnt_q     <= cnt_d;
      code_q    <= code_d;
      multi_q   <= multi_d;
      inv_q     <= inv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cap_d   = cap_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    inv_d   = 1'b0;
    multi_d = (btn_q == '0) ? 1'b0 : multi_q;
    unique case (state_q)
      S_IDLE: begin
        if (en_q && !en_prev_q) state_d = S_ARMED;
      end
      S_ARMED: begin
        if (!en_q) begin
          state_d = S_IDLE;
        end else if (tmo_hit) begin
          state_d = S_RELEASE;
        end else if ($onehot(btn_q)) begin
          cap_d = btn_q;
          cnt_d = '0;
          if (DEB_CYCLES == 1) begin
            state_d = S_PRESENT;
            code_d  = code_of(btn_q);
          end else begin
            state_d = S_DEBOUNCE;
          end
        end else if (btn_q != '0) begin
          inv_d   = !multi_q;
          multi_d = 1'b1;
        end
      end
      S_DEBOUNCE: begin
        if (!en_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (tmo_hit) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
        end else if (btn_q == cap_q) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q >= CNT_LAST) begin
            state_d = S_PRESENT;
            code_d  = code_of(cap_q);
          end
        end else begin
          state_d = S_ARMED;
          cnt_d   = '0;
        end
      end
      S_PRESENT: begin
        if (vote_ack) begin
          state_d = S_RELEASE;
          code_d  = '0;
        end
      end
      S_RELEASE: begin
        if (btn_q == '0 && !en_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    vote_valid    = (state_q == S_PRESENT);
    vote_code     = (state_q == S_PRESENT) ? code_q : '0;
    ready_led     = (state_q == S_ARMED) || (state_q == S_DEBOUNCE);
    busy_led      = (state_q == S_PRESENT) || (state_q == S_RELEASE);
    invalid_press = inv_q;
  end

`ifdef BALLOT_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tcnt_q;
  logic          tmo_q;

  // Counter runs across ARMED<->DEBOUNCE and is cleared everywhere else, so each arming restarts it.
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      tmo_q <= tmo_hit && en_q;
      if ((state_q == S_ARMED || state_q == S_DEBOUNCE) && !tmo_hit) tcnt_q <= tcnt_q + 1'b1;
      else                                                          tcnt_q <= '0;
    end
  end

  assign tmo_hit = (state_q == S_ARMED || state_q == S_DEBOUNCE) && (tcnt_q == TMO_LAST);
  assign timeout = tmo_q;
`else
  assign tmo_hit = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ballot_entry_unit.sv
// Self-checking bench for ballot_entry_unit: directed scenarios plus randomized traffic
// compared every cycle against a behavioural model of the voting rules.
module tb_ballot_entry_unit;

`ifdef BALLOT_TIMEOUT_EN
  localparam int unsigned TMO = 10;
`else
  localparam int unsigned TMO = 1000;
`endif
  localparam int unsigned NC  = 15;
  localparam int unsigned DEB = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ballot_en = 1'b0;
  logic          vote_ack = 1'b0;
  logic [NC-1:0] btn = '0;
  logic [3:0]    vote_code;
  logic          vote_valid, ready_led, busy_led, invalid_press, timeout;

  always #5 clk = ~clk;

  ballot_entry_unit #(
    .NUM_CAND      (NC),
    .DEB_CYCLES    (DEB),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ballot_en    (ballot_en),
    .btn          (btn),
    .vote_code    (vote_code),
    .vote_valid   (vote_valid),
    .vote_ack     (vote_ack),
    .ready_led    (ready_led),
    .busy_led     (busy_led),
    .invalid_press(invalid_press),
    .timeout      (timeout)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Behavioural model: flags for "authorized and waiting", "vote on offer", "vote spent",
  // plus the length of the current stable single-button run seen while authorized.
  bit          m_armed, m_offer, m_spent, m_lock, m_inv, m_tmo;
  int unsigned m_run, m_tcnt;
  logic [NC-1:0] m_vec, m_rbtn;
  logic [3:0]  m_code;
  bit          m_ren, m_ren_prev;

  function automatic logic [3:0] cand_of(input logic [NC-1:0] v);
    logic [3:0] c;
    c = '0;
    for (int k = 0; k < NC; k++) if (v[k]) c = 4'(k + 1);
    return c;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_armed = 0; m_offer = 0; m_spent = 0; m_lock = 0; m_inv = 0; m_tmo = 0;
      m_run = 0; m_tcnt = 0; m_vec = '0; m_code = '0;
      m_rbtn = '0; m_ren_prev = 1; m_ren = ballot_en;
      return;
    end
    m_inv = 0;
    m_tmo = 0;
    if (m_rbtn == '0) m_lock = 0;
    if (m_offer) begin
      if (vote_ack) begin
        m_offer = 0; m_spent = 1; m_code = '0;
      end
    end else if (m_spent) begin
      if (m_rbtn == '0 && !m_ren) m_spent = 0;
    end else if (m_armed) begin
      if (!m_ren) begin
        m_armed = 0; m_run = 0;
      end
`ifdef BALLOT_TIMEOUT_EN
      else if (m_tcnt == TMO - 1) begin
        m_armed = 0; m_run = 0; m_spent = 1; m_tmo = 1;
      end
`endif
      else begin
        m_tcnt++;
        if (m_run == 0) begin
          if ($countones(m_rbtn) == 1) begin
            m_vec = m_rbtn; m_run = 1;
          end else if (m_rbtn != '0) begin
            if (!m_lock) m_inv = 1;
            m_lock = 1;
          end
        end else if (m_rbtn == m_vec) begin
          m_run++;
        end else begin
          m_run = 0;
        end
        if (m_run == DEB) begin
          m_armed = 0; m_offer = 1; m_code = cand_of(m_vec); m_run = 0;
        end
      end
    end else if (m_ren && !m_ren_prev) begin
      m_armed = 1; m_run = 0; m_tcnt = 0;
    end
    m_ren_prev = m_ren;
    m_ren      = ballot_en;
    m_rbtn     = btn;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("valid", {31'b0, vote_valid}, {31'b0, m_offer});
    chk("code", {28'b0, vote_code}, m_offer ? {28'b0, m_code} : 32'd0);
    chk("ready", {31'b0, ready_led}, {31'b0, m_armed});
    chk("busy", {31'b0, busy_led}, {31'b0, m_offer | m_spent});
    chk("invalid", {31'b0, invalid_press}, {31'b0, m_inv});
    chk("timeout", {31'b0, timeout}, {31'b0, m_tmo});
  endtask

  task automatic wait_valid(input int unsigned limit, output int unsigned n);
    n = 0;
    while (n <= limit) begin
      tick();
      n++;
      if (vote_valid) break;
    end
  endtask

  task automatic arm();
    ballot_en = 1'b1;
    tick();
    tick();
  endtask

  task automatic finish_vote();
    vote_ack = 1'b1;
    tick();
    vote_ack = 1'b0;
    btn = '0;
    ballot_en = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    int unsigned n, cnt, hold;
    logic [NC-1:0] v;

    repeat (3) tick();
    chk("rst_outputs", {25'b0, vote_valid, vote_code, ready_led, busy_led, invalid_press}, 32'd0);
    rst = 1'b0;
    tick();

    // Basic vote, latency and release
    arm();
    chk("s1_armed", {31'b0, ready_led}, 32'd1);
    btn = NC'(1) << 2;
    wait_valid(12, n);
    chk("s1_latency", n, 32'd5);
    chk("s1_code", {28'b0, vote_code}, 32'd3);
    tick();
    btn = '0;
    tick();
    vote_ack = 1'b1;
    tick();
    vote_ack = 1'b0;
    chk("s1_valid_drop", {31'b0, vote_valid}, 32'd0);
    chk("s1_busy", {31'b0, busy_led}, 32'd1);
    repeat (3) tick();
    chk("s1_busy_hold", {31'b0, busy_led}, 32'd1);
    ballot_en = 1'b0;
    repeat (3) tick();
    chk("s1_idle", {30'b0, busy_led, ready_led}, 32'd0);

    // Multi-press rejection then a valid press on the top candidate
    arm();
    cnt = 0;
    btn = NC'(5);
    repeat (3) begin tick(); cnt += invalid_press; end
    btn = '0;
    tick(); cnt += invalid_press;
    btn = NC'(1) << 14;
    repeat (5) begin tick(); cnt += invalid_press; end
    chk("s2_inv_pulses", cnt, 32'd1);
    chk("s2_valid", {31'b0, vote_valid}, 32'd1);
    chk("s2_code", {28'b0, vote_code}, 32'd15);
    finish_vote();

    // Bounce: short burst rejected, full burst accepted
    arm();
    cnt = 0;
    btn = NC'(1);
    repeat (3) begin tick(); cnt += vote_valid; end
    btn = '0;
    tick(); cnt += vote_valid;
    tick(); cnt += vote_valid;
    chk("s3_bounce", cnt, 32'd0);
    btn = NC'(1);
    repeat (4) tick();
    btn = '0;
    tick();
    chk("s3_valid", {31'b0, vote_valid}, 32'd1);
    chk("s3_code", {28'b0, vote_code}, 32'd1);
    finish_vote();

    // One vote per authorization
    arm();
    btn = NC'(1) << 4;
    wait_valid(12, n);
    vote_ack = 1'b1;
    tick();
    vote_ack = 1'b0;
    cnt = 0;
    repeat (20) begin tick(); cnt += vote_valid; end
    chk("s4_second_vote", cnt, 32'd0);
    btn = '0;
    ballot_en = 1'b0;
    repeat (3) tick();
    arm();
    btn = NC'(1) << 4;
    wait_valid(12, n);
    chk("s4_rearm_code", {28'b0, vote_code}, 32'd5);
    finish_vote();

    // Reset while a vote is on offer
    arm();
    btn = NC'(1) << 6;
    wait_valid(12, n);
    chk("s5_code", {28'b0, vote_code}, 32'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("s5_rst_outputs", {25'b0, vote_valid, vote_code, ready_led, busy_led, invalid_press}, 32'd0);
    cnt = 0;
    repeat (10) begin tick(); cnt += vote_valid + ready_led; end
    chk("s5_no_rearm", cnt, 32'd0);
    btn = '0;
    ballot_en = 1'b0;
    repeat (3) tick();

    // Idle authorization
    arm();
`ifdef BALLOT_TIMEOUT_EN
    n = 0;
    while (n < 60) begin
      tick();
      n++;
      if (timeout) break;
    end
    chk("s6_timeout_lat", n, 32'd10);
    chk("s6_ready", {31'b0, ready_led}, 32'd0);
    chk("s6_busy", {31'b0, busy_led}, 32'd1);
`else
    cnt = 0;
    repeat (50) begin tick(); cnt += timeout; end
    chk("s6_no_timeout", cnt, 32'd0);
    chk("s6_still_armed", {31'b0, ready_led}, 32'd1);
`endif
    ballot_en = 1'b0;
    repeat (3) tick();

    // Randomized traffic
    hold = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold == 0) begin
        hold = $urandom_range(1, 8);
        n = $urandom_range(0, 99);
        if (n < 50) begin
          btn = '0;
        end else if (n < 85) begin
          v = NC'(1) << $urandom_range(0, NC - 1);
          btn = v;
        end else begin
          v = NC'($urandom);
          btn = v;
        end
      end
      hold--;
      if ($urandom_range(0, 19) == 0) ballot_en = ~ballot_en;
      vote_ack = ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    vote_ack = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
